// File: rtl/io_hub_pkg.sv
// Shared constants for the I/O peripheral hub: 7-segment patterns and
// bit positions of the fields packed into the CPU port words.
package io_hub_pkg;

  localparam int unsigned ACK_LSB   = 0;
  localparam int unsigned DP_LSB    = 8;
  localparam int unsigned BLANK_BIT = 31;
  localparam int unsigned LEVEL_LSB = 4;

  // Active-low segment patterns ordered {g,f,e,d,c,b,a}, indexed by hex digit.
  localparam logic [6:0] HEX7SEG_N [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg_n(input logic [3:0] v);
    return HEX7SEG_N[v];
  endfunction

endpackage

// File: rtl/io_peripheral_hub_if.sv
// CPU memory-mapped port bundle: three CPU output words into the hub,
// two input words back to the CPU.
interface io_peripheral_hub_if;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;
  logic [31:0] in_port0;
  logic [31:0] in_port1;

  modport master (output out_port0, out_port1, out_port2, input in_port0, in_port1);
  modport slave  (input out_port0, out_port1, out_port2, output in_port0, in_port1);
endinterface

// File: rtl/io_debounce.sv
// One-bit 2-flop synchroniser followed by a mismatch-count debouncer;
// the stable level only moves after DB_CYCLES consecutive mismatches.
module io_debounce #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter logic        RST_LEVEL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o
);
  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) level_d = sync2_q;
      else                             cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= RST_LEVEL;
      sync2_q <= RST_LEVEL;
      level_q <= RST_LEVEL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
endmodule

// File: rtl/io_peripheral_hub.sv
// Board-side end of the CPU I/O ports: debounced switches/keys with sticky
// press flags, LED drive and a multiplexed 7-segment display scanner.
module io_peripheral_hub
  import io_hub_pkg::*;
#(
  parameter int unsigned NSW         = 10,
  parameter int unsigned NKEY        = 4,
  parameter int unsigned NDIG        = 8,
  parameter int unsigned DB_CYCLES   = 500000,
  parameter int unsigned SCAN_CYCLES = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NSW-1:0]      sw,
  input  logic [NKEY-1:0]     key_n,
  io_peripheral_hub_if.slave  bus,
  output logic [NSW-1:0]      led,
  output logic [NDIG-1:0]     an_n,
  output logic [6:0]          seg_n,
  output logic                dp_n
);
  localparam int unsigned SCW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned IW  = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [NSW-1:0]  sw_level;
  logic [NKEY-1:0] key_level;

  for (genvar i = 0; i < NSW; i++) begin : g_sw
    io_debounce #(.DB_CYCLES(DB_CYCLES), .RST_LEVEL(1'b0)) u_db (
      .clk_i(clock), .rst_i(reset), .raw_i(sw[i]), .level_o(sw_level[i])
    );
  end

  for (genvar i = 0; i < NKEY; i++) begin : g_key
    io_debounce #(.DB_CYCLES(DB_CYCLES), .RST_LEVEL(1'b1)) u_db (
      .clk_i(clock), .rst_i(reset), .raw_i(key_n[i]), .level_o(key_level[i])
    );
  end

  logic [NKEY-1:0] key_prev_q, ack_prev_q, flag_q, flag_d;
  logic [NKEY-1:0] key_press, ack_rise, ack_now;
  logic [31:0]     in0_q, in0_d, in1_q, in1_d;
  logic [NSW-1:0]  led_q;
  logic [SCW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NDIG-1:0] an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   dp_bits;
  logic              unused_ports;

  assign ack_now = bus.out_port2[ACK_LSB +: NKEY];
  assign digits  = bus.out_port0[4*NDIG-1:0];
  assign dp_bits = bus.out_port2[DP_LSB +: NDIG];
  assign unused_ports = ^{bus.out_port1, bus.out_port2};

  // Press is a 1->0 step of the stable level; a press in the same clock as
  // an ack edge must survive, so the set term is applied after the clear.
  always_comb begin
    key_press = key_prev_q & ~key_level;
    ack_rise  = ack_now & ~ack_prev_q;
    flag_d    = (flag_q & ~ack_rise) | key_press;
    in0_d     = '0;
    in0_d[NSW-1:0] = sw_level;
    in1_d     = '0;
    in1_d[LEVEL_LSB +: NKEY] = ~key_level;
    in1_d[NKEY-1:0]          = flag_d;
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SCW'(SCAN_CYCLES - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end
    an_d  = bus.out_port2[BLANK_BIT] ? '1 : ~(NDIG'(1) << idx_q);
    seg_d = hex_to_seg_n(digits[{idx_q, 2'b00} +: 4]);
    dp_d  = ~dp_bits[idx_q];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_prev_q <= '1;
      ack_prev_q <= '0;
      flag_q     <= '0;
      in0_q      <= '0;
      in1_q      <= '0;
      led_q      <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= '1;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      key_prev_q <= key_level;
      ack_prev_q <= ack_now;
      flag_q     <= flag_d;
      in0_q      <= in0_d;
      in1_q      <= in1_d;
      led_q      <= bus.out_port1[NSW-1:0];
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.in_port0 = in0_q;
  assign bus.in_port1 = in1_q;
  assign led          = led_q;
  assign an_n         = an_q;
  assign seg_n        = seg_q;
  assign dp_n         = dp_q;
endmodule

// File: doc/io_peripheral_hub.md
Name: io_peripheral_hub

Overview:
- Board-side endpoint of the CPU's memory-mapped I/O ports: the device end that the data-memory stage's port registers talk to.
- Consumes the three CPU output ports: 8-digit multiplexed hex display, LEDs, and acknowledge/control bits.
- Produces the two CPU input ports from synchronised, debounced switches and sticky pushbutton press flags.
- Sits at the top level between the pipelined CPU and the board pins.

Parameters:
- NSW, 10, number of slide switches.
- NKEY, 4, number of pushbuttons (in_port1 bit map below is fixed for NKEY=4).
- NDIG, 8, number of 7-segment digits scanned.
- DB_CYCLES, 500000, consecutive mismatch clocks needed to accept a new input level.
- SCAN_CYCLES, 50000, clocks each digit stays lit.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- sw  in  NSW  raw switches, asynchronous, active-high
- key_n  in  NKEY  raw pushbuttons, asynchronous, active-low
- out_port0  in  32  CPU output port 0: display value, digit i = bits [4i+3:4i]
- out_port1  in  32  CPU output port 1: bits [NSW-1:0] drive LEDs
- out_port2  in  32  CPU output port 2: [3:0] key-flag ack, [15:8] decimal points, [31] display blank
- in_port0  out  32  {zeros, debounced sw}
- in_port1  out  32  {24'b0, pressed levels [7:4], sticky flags [3:0]}
- led  out  NSW  LED drive
- an_n  out  NDIG  digit enables, active-low one-hot
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_n  out  1  decimal point, active-low

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. All outputs are registered.
- Reset values:
  - in_port0 = 0, in_port1 = 0, led = 0.
  - an_n = all 1, seg_n = 7'h7F, dp_n = 1.
  - Digit index = 0, scan counter = 0, all debounce counters = 0.
  - Stable switch levels = 0; stable key levels = released (1); flags = 0; ack history = 0.
- Synchroniser: each sw and key_n bit passes through a 2-flop synchroniser.
- Debounce, per bit:
  - If synced level equals the stable level, the counter is cleared.
  - Otherwise the counter increments.
  - When a mismatch is seen with counter == DB_CYCLES-1, the stable level takes the synced level and the counter clears.
  - A glitch shorter than DB_CYCLES clocks never changes the stable level.
- Latency: raw edge -> in_port update takes exactly 2 + DB_CYCLES + 1 clocks.
- Key flags:
  - A stable key transition 1->0 (press) sets flag[i].
  - A rising edge on out_port2[i] (compared with its value one clock earlier) clears flag[i].
  - If set and clear occur in the same clock, set wins.
  - Release never changes a flag.
  - Holding ack high clears the flag only once; later presses set it again.
- in_port1[7:4] = inverted stable key levels, so a held key reads 1.
- LEDs: led <= out_port1[NSW-1:0], 1-clock latency.
- Display scan:
  - Scan counter counts 0..SCAN_CYCLES-1 and wraps.
  - On wrap, the digit index increments modulo NDIG; index NDIG-1 wraps to 0.
  - an_n = ~(1 << index).
  - seg_n = active-low hex pattern of the selected nibble of out_port0.
  - dp_n = ~out_port2[8+index].
  - Display outputs reflect port values with 1-clock latency, and the nibble is re-read every clock, so port writes mid-digit show immediately.
  - out_port2[31] = 1 forces an_n to all 1; scanning continues.
- Reset mid-operation: all state returns to reset values immediately. After release, debounce restarts from a stable level of 0 / released, so a switch held high re-qualifies after the full latency.

Decomposition:
- Package io_hub_pkg holds:
  - the 16-entry hex-to-segment constant table (0 = 7'h40 active-low, 8 = 7'h00, F = 7'h0E);
  - bit-index constants for out_port2 fields (ACK_LSB = 0, DP_LSB = 8, BLANK_BIT = 31);
  - bit-index constants for the in_port1 field (LEVEL_LSB = 4).
- Sub-module io_debounce:
  - one bit: 2-flop synchroniser, counter and stable register;
  - parameters DB_CYCLES and reset level;
  - instantiated NSW + NKEY times.

Test Plan (all scenarios use DB_CYCLES=4, SCAN_CYCLES=3):
- Reset: assert reset mid-scan -> an_n=8'hFF, seg_n=7'h7F, in_port0=0, in_port1=0, led=0 in the same cycle, without waiting for a clock edge.
- Switch qualify: sw 0->10'h2A5, held -> in_port0=32'h2A5 exactly 7 clocks later. A 3-clock glitch on sw[0] -> in_port0 unchanged.
- Key flag: key_n[1] low for 10 clocks -> in_port1=32'h22 while held, 32'h02 after release. out_port2 0->1 on bit 1 -> in_port1=0 next clock. Ack held high plus a second press -> flag set again.
- Simultaneous: press qualification and ack rising edge land on the same clock -> flag remains 1.
- Scan: out_port0=32'h8765_4321, out_port2[15:8]=8'h01 -> an_n steps FE,FD,...,7F every 3 clocks, then wraps to FE. seg_n shows the patterns for 1..8, with dp_n=0 only on digit 0. Setting out_port2[31]=1 -> an_n=FF.
- LEDs: out_port1=32'hFFFF_F3C1 -> led=10'h3C1 next clock.
